// File: rtl/ram_arbiter.sv
// Two-port round-robin front end for a single-port RAM with registered read.
// One access in flight at a time; all outputs come straight from flops.
//
// state  | meaning
// IDLE   | sample requests, pick a winner, latch its command
// CMD    | command on the RAM port, grant pulse to the winner
// RDWAIT | RAM read data arriving, captured at the closing edge
module ram_arbiter #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [AW-1:0]    addr0,
  input  logic [AW-1:0]    addr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [WIDTH-1:0] rdata0,
  output logic [WIDTH-1:0] rdata1,
  output logic             ram_w_en,
  output logic [AW-1:0]    ram_addr,
  output logic [WIDTH-1:0] ram_data_in,
  input  logic [WIDTH-1:0] ram_data_out
);

  typedef enum logic [1:0] {IDLE, CMD, RDWAIT} state_t;

  state_t           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             owner_q, owner_d;
  logic             cmd_we_q, cmd_we_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             rvalid0_q, rvalid0_d;
  logic             rvalid1_q, rvalid1_d;
  logic [WIDTH-1:0] rdata0_q, rdata0_d;
  logic [WIDTH-1:0] rdata1_q, rdata1_d;
  logic             ram_w_en_q, ram_w_en_d;
  logic [AW-1:0]    ram_addr_q, ram_addr_d;
  logic [WIDTH-1:0] ram_data_in_q, ram_data_in_d;
  logic             win1;

  // Port 1 wins when it is alone, or when both ask and port 0 went last.
  assign win1 = req1 & (~req0 | ~last_grant_q);

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    owner_d       = owner_q;
    cmd_we_d      = cmd_we_q;
    gnt0_d        = 1'b0;
    gnt1_d        = 1'b0;
    rvalid0_d     = 1'b0;
    rvalid1_d     = 1'b0;
    rdata0_d      = rdata0_q;
    rdata1_d      = rdata1_q;
    ram_w_en_d    = 1'b0;
    ram_addr_d    = ram_addr_q;
    ram_data_in_d = ram_data_in_q;
    case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          owner_d       = win1;
          last_grant_d  = win1;
          cmd_we_d      = win1 ? we1 : we0;
          ram_w_en_d    = win1 ? we1 : we0;
          ram_addr_d    = win1 ? addr1 : addr0;
          ram_data_in_d = win1 ? wdata1 : wdata0;
          gnt0_d        = ~win1;
          gnt1_d        = win1;
          state_d       = CMD;
        end
      end
      CMD: begin
        state_d = cmd_we_q ? IDLE : RDWAIT;
      end
      RDWAIT: begin
        if (owner_q) begin
          rdata1_d  = ram_data_out;
          rvalid1_d = 1'b1;
        end else begin
          rdata0_d  = ram_data_out;
          rvalid0_d = 1'b1;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      owner_q       <= 1'b0;
      cmd_we_q      <= 1'b0;
      gnt0_q        <= 1'b0;
      gnt1_q        <= 1'b0;
      rvalid0_q     <= 1'b0;
      rvalid1_q     <= 1'b0;
      rdata0_q      <= '0;
      rdata1_q      <= '0;
      ram_w_en_q    <= 1'b0;
      ram_addr_q    <= '0;
      ram_data_in_q <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      owner_q       <= owner_d;
      cmd_we_q      <= cmd_we_d;
      gnt0_q        <= gnt0_d;
      gnt1_q        <= gnt1_d;
      rvalid0_q     <= rvalid0_d;
      rvalid1_q     <= rvalid1_d;
      rdata0_q      <= rdata0_d;
      rdata1_q      <= rdata1_d;
      ram_w_en_q    <= ram_w_en_d;
      ram_addr_q    <= ram_addr_d;
      ram_data_in_q <= ram_data_in_d;
    end
  end

  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign rvalid0     = rvalid0_q;
  assign rvalid1     = rvalid1_q;
  assign rdata0      = rdata0_q;
  assign rdata1      = rdata1_q;
  assign ram_w_en    = ram_w_en_q;
  assign ram_addr    = ram_addr_q;
  assign ram_data_in = ram_data_in_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic, all cycles
// checked against a transaction-level model (memory array + grant schedule).
module tb_ram_arbiter;
  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int AW    = 3;
  localparam int MAXC  = 4096;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1, we0, we1;
  logic [AW-1:0]    addr0, addr1;
  logic [WIDTH-1:0] wdata0, wdata1;
  logic             gnt0, gnt1, rvalid0, rvalid1;
  logic [WIDTH-1:0] rdata0, rdata1;
  logic             ram_w_en;
  logic [AW-1:0]    ram_addr;
  logic [WIDTH-1:0] ram_data_in;
  logic [WIDTH-1:0] ram_data_out;

  ram_arbiter #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .ram_w_en(ram_w_en), .ram_addr(ram_addr), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out)
  );

  always #5 clk = ~clk;

  // single-port RAM with registered read
  logic [WIDTH-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (ram_w_en) ram[ram_addr] <= ram_data_in;
    ram_data_out <= ram[ram_addr];
  end

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  // reference model state; cycle k is the interval after clock edge k
  logic [WIDTH-1:0] mem [DEPTH];
  bit               erv0 [MAXC];
  bit               erv1 [MAXC];
  logic [WIDTH-1:0] erd0 [MAXC];
  logic [WIDTH-1:0] erd1 [MAXC];
  int               free_at = 0;
  bit               last = 1'b1;
  bit               mg0, mg1, mwen;
  logic [WIDTH-1:0] mrd0, mrd1, mdin;
  logic [AW-1:0]    maddr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_edge();
    bit               w;
    bit               cw;
    logic [AW-1:0]    a;
    logic [WIDTH-1:0] d;
    mg0  = 1'b0;
    mg1  = 1'b0;
    mwen = 1'b0;
    if (rst) begin
      for (int k = cyc; k < MAXC; k++) begin
        erv0[k] = 1'b0;
        erv1[k] = 1'b0;
      end
      mrd0 = '0; mrd1 = '0; maddr = '0; mdin = '0;
      last = 1'b1;
      free_at = cyc + 1;
    end else begin
      if (erv0[cyc]) mrd0 = erd0[cyc];
      if (erv1[cyc]) mrd1 = erd1[cyc];
      if (cyc >= free_at && (req0 || req1)) begin
        w  = (req0 && req1) ? !last : req1;
        last = w;
        cw = w ? we1 : we0;
        a  = w ? addr1 : addr0;
        d  = w ? wdata1 : wdata0;
        if (w) mg1 = 1'b1; else mg0 = 1'b1;
        maddr = a;
        mdin  = d;
        if (cw) begin
          mem[a]  = d;
          mwen    = 1'b1;
          free_at = cyc + 2;
        end else begin
          if (w) begin erv1[cyc+2] = 1'b1; erd1[cyc+2] = mem[a]; end
          else   begin erv0[cyc+2] = 1'b1; erd0[cyc+2] = mem[a]; end
          free_at = cyc + 3;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("gnt0",        32'(gnt0),        32'(mg0));
    chk("gnt1",        32'(gnt1),        32'(mg1));
    chk("rvalid0",     32'(rvalid0),     32'(erv0[cyc]));
    chk("rvalid1",     32'(rvalid1),     32'(erv1[cyc]));
    chk("rdata0",      32'(rdata0),      32'(mrd0));
    chk("rdata1",      32'(rdata1),      32'(mrd1));
    chk("ram_w_en",    32'(ram_w_en),    32'(mwen));
    chk("ram_addr",    32'(ram_addr),    32'(maddr));
    chk("ram_data_in", 32'(ram_data_in), 32'(mdin));
  endtask

  task automatic tick();
    @(posedge clk);
    cyc++;
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  // Present a command on port p and hold it until the grant, then drop req.
  task automatic issue(input int p, input bit w, input int a, input int d, output int gc);
    int n;
    n  = 0;
    gc = -1;
    if (p == 0) begin req0 = 1'b1; we0 = w; addr0 = a[AW-1:0]; wdata0 = d[WIDTH-1:0]; end
    else        begin req1 = 1'b1; we1 = w; addr1 = a[AW-1:0]; wdata1 = d[WIDTH-1:0]; end
    while (gc < 0 && n < 20) begin
      tick();
      n++;
      if ((p == 0 && mg0) || (p == 1 && mg1)) gc = cyc;
    end
    if (p == 0) req0 = 1'b0; else req1 = 1'b0;
    tests++;
    assert (gc >= 0) else begin
      fails++;
      $error("FAIL grant_timeout: port %0d observed no grant expected grant within 20 cycles", p);
    end
  endtask

  initial begin
    int gc;
    int order[$];
    bit prev_g, g;
    bit pend0, pend1;
    int rd_addr [3];
    logic [WIDTH-1:0] rd_exp [3];

    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    repeat (3) tick();
    rst = 1'b0;

    for (int i = 0; i < DEPTH; i++) issue(0, 1'b1, i, i * 17 + 1, gc);

    // port 0 writes, port 1 reads back: gnt at +1, rvalid at +3
    issue(0, 1'b1, 3, 'hA5, gc);
    issue(1, 1'b0, 3, 0, gc);
    chk("t23_gnt1", 32'(gnt1), 32'd1);
    tick();
    chk("t23_rvalid1_early", 32'(rvalid1), 32'd0);
    tick();
    chk("t23_rvalid1", 32'(rvalid1), 32'd1);
    chk("t23_rdata1", 32'(rdata1), 32'hA5);

    // both ports contend right after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req0 = 1'b1; we0 = 1'b0; addr0 = 3'd1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 3'd2;
    prev_g = 1'b0;
    for (int i = 0; i < 24; i++) begin
      tick();
      g = gnt0 | gnt1;
      chk("t24_no_back_to_back", 32'(prev_g & g), 32'd0);
      prev_g = g;
      if (gnt0) order.push_back(0);
      if (gnt1) order.push_back(1);
      req0 = !mg0;
      req1 = !mg1;
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (3) tick();
    chk("t24_grant_count_ge4", 32'(order.size() >= 4), 32'd1);
    for (int i = 0; i < 4 && i < order.size(); i++)
      chk("t24_order", 32'(order[i]), 32'(i % 2));

    // port 1 alone: writes then reads
    issue(1, 1'b1, 0, 'hFF, gc);
    issue(1, 1'b1, 7, 'h01, gc);
    rd_addr = '{0, 7, 7};
    rd_exp  = '{8'hFF, 8'h01, 8'h01};
    for (int i = 0; i < 3; i++) begin
      issue(1, 1'b0, rd_addr[i], 0, gc);
      chk("t25_gnt1", 32'(gnt1), 32'd1);
      tick();
      tick();
      chk("t25_rvalid1", 32'(rvalid1), 32'd1);
      chk("t25_rdata1", 32'(rdata1), 32'(rd_exp[i]));
    end

    // reset during RDWAIT aborts the read
    issue(0, 1'b0, 4, 0, gc);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t26_rvalid0", 32'(rvalid0), 32'd0);
    chk("t26_all_zero", 32'({gnt0, gnt1, rvalid1, ram_w_en}), 32'd0);
    chk("t26_bus_zero", 32'({ram_addr, ram_data_in, rdata0, rdata1}), 32'd0);
    req1 = 1'b1; we1 = 1'b0; addr1 = 3'd1;
    tick();
    chk("t26_idle_gnt1", 32'(gnt1), 32'd1);
    req1 = 1'b0;
    repeat (3) begin
      tick();
      chk("t26_no_rvalid0", 32'(rvalid0), 32'd0);
    end

    // reset during CMD of a write: the write lands once and is not repeated
    issue(0, 1'b1, 5, 'h3C, gc);
    chk("t27_w_en_cmd", 32'(ram_w_en), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (3) begin
      chk("t27_no_rewrite", 32'(ram_w_en), 32'd0);
      tick();
    end
    issue(1, 1'b0, 5, 0, gc);
    tick();
    tick();
    chk("t27_rdata1", 32'(rdata1), 32'h3C);

    // address change during RDWAIT does not disturb the read in flight
    issue(0, 1'b1, 2, 'h5A, gc);
    issue(0, 1'b0, 2, 0, gc);
    tick();
    req0 = 1'b1; we0 = 1'b0; addr0 = 3'd6;
    tick();
    chk("t28_rvalid0", 32'(rvalid0), 32'd1);
    chk("t28_rdata0", 32'(rdata0), 32'h5A);
    gc = -1;
    for (int i = 0; i < 10 && gc < 0; i++) begin
      tick();
      if (mg0) gc = cyc;
    end
    chk("t28_next_gnt0", 32'(gnt0), 32'd1);
    chk("t28_next_addr", 32'(ram_addr), 32'd6);
    req0 = 1'b0;
    repeat (3) tick();

    // random traffic with occasional resets
    pend0 = 1'b0; pend1 = 1'b0;
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      tick();
      if (mg0) pend0 = 1'b0;
      if (mg1) pend1 = 1'b0;
      if (!pend0) begin
        pend0  = 1'($urandom_range(0, 1));
        req0   = pend0;
        we0    = 1'($urandom_range(0, 1));
        addr0  = 3'($urandom_range(0, DEPTH - 1));
        wdata0 = 8'($urandom_range(0, 255));
      end
      if (!pend1) begin
        pend1  = 1'($urandom_range(0, 1));
        req1   = pend1;
        we1    = 1'($urandom_range(0, 1));
        addr1  = 3'($urandom_range(0, DEPTH - 1));
        wdata1 = 8'($urandom_range(0, 255));
      end
    end
    rst = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    repeat (5) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, number of RAM words (power of two, >= 2).
REQ-002 The block SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-003 The block SHALL derive AW = $clog2(DEPTH) as the address width.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high.
REQ-005 Port list (name, direction, width, meaning):
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- req0, req1  input  1  access request from requester 0 / 1.
- we0, we1  input  1  1 = write, 0 = read; valid while reqN high.
- addr0, addr1  input  AW  word address; valid while reqN high.
- wdata0, wdata1  input  WIDTH  write data; valid while reqN high.
- gnt0, gnt1  output  1  one-cycle grant pulse; the command is on the RAM port in that cycle.
- rvalid0, rvalid1  output  1  one-cycle read-data-valid pulse.
- rdata0, rdata1  output  WIDTH  read data; held until the next read by that port.
- ram_w_en  output  1  to single_port_RAM w_en.
- ram_addr  output  AW  to single_port_RAM addr.
- ram_data_in  output  WIDTH  to single_port_RAM data_in.
- ram_data_out  input  WIDTH  from single_port_RAM data_out; registered read, valid one cycle after the read address is presented.

Function
REQ-006 All outputs SHALL be registered.
REQ-007 The FSM SHALL have states IDLE, CMD and RDWAIT.
REQ-008 The FSM SHALL sample requests only in IDLE.
REQ-009 In IDLE with any reqN high, the FSM SHALL latch the winner's we/addr/wdata into ram_w_en/ram_addr/ram_data_in, set gntN for the next cycle, and go to CMD.
REQ-010 In IDLE with no request, the FSM SHALL stay in IDLE with ram_w_en = 0.
REQ-011 CMD SHALL last exactly one cycle: gnt of the winner = 1 and ram_w_en = latched we.
- Write: the next state SHALL be IDLE.
- Read: the next state SHALL be RDWAIT.
REQ-012 RDWAIT SHALL last one cycle; at its closing edge ram_data_out SHALL be captured into rdataN of the read's owner, and rvalidN SHALL be 1 in the following cycle; the next state SHALL be IDLE.
REQ-013 Latency, from the request-sampling edge: gnt is high in cycle +1; rvalid is high in cycle +3. Peak throughput is one write per 2 cycles or one read per 3 cycles.
REQ-014 ram_w_en SHALL be 0 in every state other than CMD of a write; ram_addr and ram_data_in SHALL hold their last values when not updated.
REQ-015 Arbitration SHALL be round-robin using a last_grant register:
- Both requesting: grant the port that is not last_grant.
- One requesting: grant that port regardless of last_grant.
- last_grant SHALL update only on a grant.
REQ-016 A requester SHALL hold req/we/addr/wdata stable until it sees gntN. If req remains high in the first IDLE after gnt, it SHALL be treated as a new request.
REQ-017 Changes to req, we, addr or wdata during CMD or RDWAIT SHALL have no effect on the command in flight.
REQ-018 At most one of gnt0/gnt1 SHALL be high in any cycle, and at most one of rvalid0/rvalid1 SHALL be high in any cycle.
REQ-019 Address arithmetic SHALL be pass-through only: no offset and no wrap logic; addresses 0..DEPTH-1 SHALL all be reachable.

Reset
REQ-020 When rst = 1 at a clock edge, the block SHALL, on that edge:
- go to IDLE;
- set last_grant = 1, so port 0 wins the first contention;
- clear gnt0, gnt1, rvalid0, rvalid1, ram_w_en, ram_addr, ram_data_in, rdata0 and rdata1 to 0.
REQ-021 A reset during CMD or RDWAIT SHALL abort the access: no rvalid is produced, and an aborted write is not re-issued.
REQ-022 Requests SHALL be ignored while rst = 1; the first sampling SHALL occur at the first edge with rst = 0.

Verification (DEPTH = 8, WIDTH = 8)
REQ-023 Port 0 writes addr 3 = 0xA5, then port 1 reads addr 3 -> gnt1 in cycle +1, rvalid1 in cycle +3, rdata1 = 0xA5.
REQ-024 req0 and req1 both held high after reset, each dropping req for one cycle after each gnt -> grant order 0,1,0,1; never two grants in consecutive cycles.
REQ-025 Only req1 active for 3 reads of addr 0, 7, 7 after writes 0 = 0xFF and 7 = 0x01 -> rdata1 = 0xFF, 0x01, 0x01; all grants to port 1.
REQ-026 rst asserted during RDWAIT of a port-0 read -> rvalid0 stays 0; all outputs are 0 the next cycle; state IDLE.
REQ-027 rst asserted during CMD of a write to addr 5 = 0x3C -> ram_w_en = 1 for that cycle only; no further write is issued; a subsequent read of addr 5 returns 0x3C.
REQ-028 req0 changes addr 2 -> 6 during RDWAIT -> rdata0 returns the addr 2 contents; the following access uses addr 6.
